add_sub_fpu: RTL and testbench
==============================

// Module: add_sub_fpu
// PURPOSE
//  IEEE-754 single-precision adder/subtractor for the RV32F execute stage (FADD.S/FSUB.S).
//  Multi-cycle: one start pulse launches an operation; ready goes high with the registered result.
//  One operation in flight at a time. Rounding is round-to-nearest-even only; no exception flags.
// PARAMETERS
//  none (widths fixed: EXP_W=8, MAN_W=23, BIAS=127)
// PORTS
//  clk      in   1   clock, all state updates on rising edge
//  rst      in   1   synchronous reset, active-high
//  start    in   1   launch operation; sampled only in IDLE or DONE
//  add_sub  in   1   0 = a+b, 1 = a-b; sampled with start
//  a        in   32  operand A (IEEE-754 single); sampled with start
//  b        in   32  operand B (IEEE-754 single); sampled with start
//  ready    out  1   result valid; level, held until next accepted start
//  result   out  32  IEEE-754 single sum/difference; held while ready=1
// BEHAVIOUR
//  Reset: state=IDLE, ready=0, result=32'h0, all internal regs cleared. Reset mid-operation aborts it.
//  FSM: IDLE -> UNPACK -> ALIGN -> ADDSUB -> NORM -> ROUND -> DONE.
//  - IDLE/DONE: start=1 latches a, b, add_sub; sets ready=0; next state UNPACK. start ignored elsewhere.
//  - UNPACK: split sign/exp/mantissa; effective sign_b = b[31]^add_sub; hidden bit 1 for exp!=0;
//    classify zero/inf/NaN; exp==0 (subnormal) inputs are flushed to signed zero.
//  - ALIGN: swap so the larger magnitude is first; shift smaller 24-bit significand right by the exponent
//    difference, keeping guard, round, sticky (sticky = OR of all shifted-out bits); diff>=26 leaves only sticky.
//  - ADDSUB: signs equal -> add magnitudes (27+1 bits); else subtract smaller from larger. Result sign = larger's sign.
//  - NORM: carry-out -> shift right 1, exp+1 (fold lost bit into sticky); else leading-zero count and shift left, exp-lzc.
//    Normalization completes in this single cycle (combinational LZC), so latency is fixed.
//  - ROUND: RNE: increment if G & (R|S|LSB); mantissa overflow -> exp+1. Pack result.
//  - DONE: ready=1, result held; stays here until start or rst.
//  Latency: start sampled at edge E0; ready=1 and result valid after edge E5; fixed, data-independent.
//  Special cases (resolved in UNPACK, bypass to DONE with same fixed latency):
//  - any NaN operand, or inf + (-inf) effective -> 32'h7FC00000 (canonical quiet NaN).
//  - one inf -> that inf with effective sign; both zero -> +0 unless both effective signs negative (-0).
//  - exact cancellation (x - x) -> +0 (32'h00000000).
//  - exponent overflow after round (>=255) -> signed inf; underflow (exp<=0) -> signed zero (flush).
//  start asserted while busy is dropped; operands may change freely after the start cycle.
// STRUCTURE
//  Package fpu_pkg: FP32 field widths, BIAS, QNAN constant, state enum typedef, unpacked-float struct.
//  One sub-module natural: fpu_lzc (24/28-bit leading-zero counter, combinational) used in NORM.
//  Datapath regs: sign, exp (10-bit signed for under/overflow), 28-bit significand w/ G/R/S.
// TESTING
//  3.2 + 4.6: a=404CCCCD b=40933333 add_sub=0 -> result=40F9999A (7.8, tie rounded to even), ready after E5.
//  3.2 - 4.6: same a,b, add_sub=1 -> result=BFB33332 (-1.4, exact difference, 2-bit left normalize).
//  1.0+2.0 -> 40400000; 1.0+1.0 -> 40000000 (carry-out renormalize, exp+1).
//  -4.0 + 4.0: C0800000 + 40800000 -> 00000000 (+0 on cancellation); -10 - (-4): C1200000,C0800000,sub -> C0C00000.
//  Specials: 7F800000 + FF800000 -> 7FC00000; 7F7FFFFF + 7F7FFFFF -> 7F800000; NaN in -> 7FC00000.
//  Control: start while busy ignored; rst asserted in ALIGN -> ready=0,result=0 next edge; back-to-back start from DONE.

Source files
------------

// File: rtl/add_sub_fpu_pkg.sv
// Shared widths, constants, state encoding and payload types for the FP32 adder/subtractor.
package add_sub_fpu_pkg;

    localparam int unsigned FP_W    = 32;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MAN_W   = 23;
    localparam int unsigned SIG_W   = MAN_W + 1;
    localparam int unsigned EXT_W   = SIG_W + 3;
    localparam int unsigned SUM_W   = EXT_W + 1;
    localparam int unsigned EXPR_W  = 10;
    localparam int unsigned LZC_W   = 5;
    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 2 * BIAS + 1;

    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADDSUB,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_e;

    typedef struct packed {
        logic            add_sub;
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
    } fpu_req_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } fop_t;

    typedef struct packed {
        fop_t op;
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } ufloat_t;

    // Split an FP32 word; subnormals collapse to a signed zero, flip negates the sign.
    function automatic ufloat_t fp_unpack(input logic [FP_W-1:0] x, input logic flip);
        ufloat_t          u;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        e         = x[FP_W-2 -: EXP_W];
        m         = x[MAN_W-1:0];
        u.is_zero = (e == '0);
        u.is_inf  = (e == '1) && (m == '0);
        u.is_nan  = (e == '1) && (m != '0);
        u.op.sign = x[FP_W-1] ^ flip;
        u.op.exp  = e;
        u.op.sig  = u.is_zero ? '0 : {1'b1, m};
        return u;
    endfunction

    function automatic logic [FP_W-1:0] fp_inf(input logic sign);
        return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    endfunction

endpackage

// File: rtl/add_sub_fpu_if.sv
// Request/response bundle between the execute stage and the FP32 adder/subtractor.
interface add_sub_fpu_if;
    import add_sub_fpu_pkg::*;

    logic            start;
    logic            add_sub;
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
    logic            ready;
    logic [FP_W-1:0] result;

    modport master (
        output start, add_sub, a, b,
        input  ready, result
    );

    modport slave (
        input  start, add_sub, a, b,
        output ready, result
    );

endinterface

// File: rtl/add_sub_fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module add_sub_fpu_lzc #(
    parameter int unsigned W  = 28,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  in_i,
    output logic [CW-1:0] cnt_c_o
);

    // Ascending scan: the highest set bit writes last and wins.
    always_comb begin
        cnt_c_o = CW'(W);
        for (int i = 0; i < int'(W); i++) begin
            if (in_i[i]) begin
                cnt_c_o = CW'(int'(W) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/add_sub_fpu.sv
// FP32 add/subtract, round-to-nearest-even, fixed six-state pipeline through a single FSM.
module add_sub_fpu
    import add_sub_fpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    add_sub_fpu_if.slave bus
);

    localparam logic signed [EXPR_W-1:0] EXP_OVF  = EXPR_W'(EXP_MAX);
    localparam logic signed [EXPR_W-1:0] EXP_ZERO = '0;

    state_e                    state_q, state_d;
    fpu_req_t                  req_q, req_d;
    fop_t                      ua_q, ua_d, ub_q, ub_d;
    logic                      spec_q, spec_d;
    logic [FP_W-1:0]           spec_res_q, spec_res_d;
    logic                      sign_q, sign_d;
    logic                      eff_sub_q, eff_sub_d;
    logic signed [EXPR_W-1:0]  exp_q, exp_d;
    logic [EXT_W-1:0]          big_q, big_d;
    logic [EXT_W-1:0]          small_q, small_d;
    logic [SUM_W-1:0]          sum_q, sum_d;
    logic [EXT_W-1:0]          norm_q, norm_d;
    logic                      ready_q, ready_d;
    logic [FP_W-1:0]           result_q, result_d;

    ufloat_t                   ua_c, ub_c;
    logic                      special_c;
    logic [FP_W-1:0]           special_res_c;
    logic                      a_big_c;
    fop_t                      lg_c, sm_c;
    logic [EXP_W-1:0]          diff_c;
    logic [EXT_W-1:0]          sm_ext_c, sm_sh_c;
    logic [LZC_W-1:0]          lz_c, shamt_c;
    logic [EXT_W-1:0]          norm_c;
    logic signed [EXPR_W-1:0]  norm_exp_c;
    logic                      inc_c;
    logic [SIG_W-1:0]          frac_r_c;
    logic signed [EXPR_W-1:0]  rexp_c;
    logic [FP_W-1:0]           round_res_c;

    assign bus.ready  = ready_q;
    assign bus.result = result_q;

    assign ua_c = fp_unpack(req_q.a, 1'b0);
    assign ub_c = fp_unpack(req_q.b, req_q.add_sub);

    // Operand classes that fully determine the answer skip the arithmetic result.
    always_comb begin
        special_c     = 1'b1;
        special_res_c = QNAN;
        if (ua_c.is_nan || ub_c.is_nan) begin
            special_res_c = QNAN;
        end else if (ua_c.is_inf && ub_c.is_inf) begin
            special_res_c = (ua_c.op.sign == ub_c.op.sign) ? fp_inf(ua_c.op.sign) : QNAN;
        end else if (ua_c.is_inf) begin
            special_res_c = fp_inf(ua_c.op.sign);
        end else if (ub_c.is_inf) begin
            special_res_c = fp_inf(ub_c.op.sign);
        end else if (ua_c.is_zero && ub_c.is_zero) begin
            special_res_c = {ua_c.op.sign & ub_c.op.sign, {(FP_W-1){1'b0}}};
        end else begin
            special_c     = 1'b0;
            special_res_c = '0;
        end
    end

    // Order by magnitude and right-align the smaller significand with a sticky jam.
    always_comb begin
        a_big_c  = {ua_q.exp, ua_q.sig} >= {ub_q.exp, ub_q.sig};
        lg_c     = a_big_c ? ua_q : ub_q;
        sm_c     = a_big_c ? ub_q : ua_q;
        diff_c   = lg_c.exp - sm_c.exp;
        sm_ext_c = {sm_c.sig, 3'b000};
        if (diff_c >= EXP_W'(EXT_W)) begin
            sm_sh_c = {{(EXT_W-1){1'b0}}, |sm_c.sig};
        end else begin
            sm_sh_c    = sm_ext_c >> diff_c;
            sm_sh_c[0] = sm_sh_c[0] | (|(sm_ext_c & ((EXT_W'(1) << diff_c) - EXT_W'(1))));
        end
    end

    add_sub_fpu_lzc #(
        .W  (SUM_W),
        .CW (LZC_W)
    ) u_lzc (
        .in_i    (sum_q),
        .cnt_c_o (lz_c)
    );

    // A zero sum shifts out completely, leaving the hidden-bit slot clear.
    always_comb begin
        shamt_c = lz_c - LZC_W'(1);
        if (sum_q[SUM_W-1]) begin
            norm_c     = {sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
            norm_exp_c = exp_q + $signed(EXPR_W'(1));
        end else begin
            norm_c     = sum_q[EXT_W-1:0] << shamt_c;
            norm_exp_c = exp_q - $signed(EXPR_W'(shamt_c));
        end
    end

    always_comb begin
        inc_c    = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
        frac_r_c = {1'b0, norm_q[EXT_W-2:3]} + SIG_W'(inc_c);
        rexp_c   = exp_q + $signed(EXPR_W'(frac_r_c[MAN_W]));
        if (spec_q) begin
            round_res_c = spec_res_q;
        end else if (!norm_q[EXT_W-1]) begin
            round_res_c = '0;
        end else if (rexp_c >= EXP_OVF) begin
            round_res_c = fp_inf(sign_q);
        end else if (rexp_c <= EXP_ZERO) begin
            round_res_c = {sign_q, {(FP_W-1){1'b0}}};
        end else begin
            round_res_c = {sign_q, rexp_c[EXP_W-1:0], frac_r_c[MAN_W-1:0]};
        end
    end

    // Next-state and per-stage register loads.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        ua_d       = ua_q;
        ub_d       = ub_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        sign_d     = sign_q;
        eff_sub_d  = eff_sub_q;
        exp_d      = exp_q;
        big_d      = big_q;
        small_d    = small_q;
        sum_d      = sum_q;
        norm_d     = norm_q;
        ready_d    = ready_q;
        result_d   = result_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    req_d.add_sub = bus.add_sub;
                    req_d.a       = bus.a;
                    req_d.b       = bus.b;
                    ready_d       = 1'b0;
                    state_d       = S_UNPACK;
                end
            end
            S_UNPACK: begin
                ua_d       = ua_c.op;
                ub_d       = ub_c.op;
                spec_d     = special_c;
                spec_res_d = special_res_c;
                state_d    = S_ALIGN;
            end
            S_ALIGN: begin
                sign_d    = lg_c.sign;
                eff_sub_d = lg_c.sign ^ sm_c.sign;
                exp_d     = $signed(EXPR_W'(lg_c.exp));
                big_d     = {lg_c.sig, 3'b000};
                small_d   = sm_sh_c;
                state_d   = S_ADDSUB;
            end
            S_ADDSUB: begin
                sum_d   = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                    : ({1'b0, big_q} + {1'b0, small_q});
                state_d = S_NORM;
            end
            S_NORM: begin
                norm_d  = norm_c;
                exp_d   = norm_exp_c;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                result_d = round_res_c;
                ready_d  = 1'b1;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            ua_q       <= '0;
            ub_q       <= '0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            sign_q     <= 1'b0;
            eff_sub_q  <= 1'b0;
            exp_q      <= '0;
            big_q      <= '0;
            small_q    <= '0;
            sum_q      <= '0;
            norm_q     <= '0;
            ready_q    <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            ua_q       <= ua_d;
            ub_q       <= ub_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            sign_q     <= sign_d;
            eff_sub_q  <= eff_sub_d;
            exp_q      <= exp_d;
            big_q      <= big_d;
            small_q    <= small_d;
            sum_q      <= sum_d;
            norm_q     <= norm_d;
            ready_q    <= ready_d;
            result_q   <= result_d;
        end
    end

endmodule

// File: tb/tb_add_sub_fpu.sv
// Bench for add_sub_fpu: directed vectors, control sequences, and random operands vs a real-arithmetic model.
module tb_add_sub_fpu;

    logic clk = 1'b0;
    logic rst;

    add_sub_fpu_if bus ();

    add_sub_fpu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] dir_a   [9];
    logic [31:0] dir_b   [9];
    logic        dir_op  [9];
    logic [31:0] dir_exp [9];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sp_to_dp(input logic [31:0] x);
        logic [7:0] e;
        e = x[30:23];
        if (e == 8'd0)   return {x[31], 63'd0};
        if (e == 8'hFF)  return {x[31], 11'h7FF, x[22:0], 29'd0};
        return {x[31], 11'(int'(e) + 896), x[22:0], 29'd0};
    endfunction

    // Exact-enough double arithmetic, then one RNE step down to single with flush-to-zero.
    function automatic logic [31:0] ref_addsub(input logic [31:0] x, input logic [31:0] y, input logic op);
        real         ra, rb, r;
        logic [63:0] d;
        logic [10:0] e11;
        logic [51:0] f;
        logic [24:0] m;
        int          es;
        ra  = $bitstoreal(sp_to_dp(x));
        rb  = $bitstoreal(sp_to_dp(y));
        r   = op ? (ra - rb) : (ra + rb);
        d   = $realtobits(r);
        e11 = d[62:52];
        f   = d[51:0];
        if (e11 == 11'h7FF) return (f != 52'd0) ? 32'h7FC00000 : {d[63], 8'hFF, 23'd0};
        if (e11 == 11'd0)   return {d[63], 31'd0};
        es = int'(e11) - 1023 + 127;
        m  = {2'b01, f[51:29]};
        if (f[28] && ((|f[27:0]) || m[0])) m = m + 25'd1;
        if (m[24]) begin
            es = es + 1;
            m  = m >> 1;
        end
        if (es >= 255) return {d[63], 8'hFF, 23'd0};
        if (es <= 0)   return {d[63], 31'd0};
        return {d[63], 8'(es), m[22:0]};
    endfunction

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic op,
                          output logic [31:0] res);
        int n;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.a       = ta;
        bus.b       = tb;
        bus.add_sub = op;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.a       = $urandom;
        bus.b       = $urandom;
        bus.add_sub = ~op;
        check_val("ready_low", 32'(bus.ready), 32'd0);
        n = 0;
        while (!bus.ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("latency", 32'(n), 32'd5);
        res = bus.result;
    endtask

    task automatic gen_operands(output logic [31:0] x, output logic [31:0] y, output logic op);
        logic [7:0] edges [6];
        int         k;
        edges = '{8'd0, 8'd1, 8'd2, 8'd253, 8'd254, 8'd255};
        x  = $urandom;
        y  = $urandom;
        op = 1'($urandom_range(0, 1));
        k  = $urandom_range(0, 3);
        case (k)
            1: y[30:23] = x[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
            2: begin
                y       = x ^ {1'($urandom_range(0, 1)), 31'd0};
                y[2:0]  = y[2:0] ^ 3'($urandom_range(0, 7));
            end
            3: begin
                x[30:23] = edges[$urandom_range(0, 5)];
                y[30:23] = edges[$urandom_range(0, 5)];
            end
            default: ;
        endcase
    endtask

    initial begin
        logic [31:0] res, ra, rb, held;
        logic        rop;
        int          n;

        dir_a   = '{32'h404CCCCD, 32'h404CCCCD, 32'h3F800000, 32'h3F800000, 32'hC0800000,
                    32'hC1200000, 32'h7F800000, 32'h7F7FFFFF, 32'h7FC00001};
        dir_b   = '{32'h40933333, 32'h40933333, 32'h40000000, 32'h3F800000, 32'h40800000,
                    32'hC0800000, 32'hFF800000, 32'h7F7FFFFF, 32'h3F800000};
        dir_op  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        dir_exp = '{32'h40F9999A, 32'hBFB33332, 32'h40400000, 32'h40000000, 32'h00000000,
                    32'hC0C00000, 32'h7FC00000, 32'h7F800000, 32'h7FC00000};

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.add_sub = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", 32'(bus.ready), 32'd0);
        check_val("rst_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(dir_a[i], dir_b[i], dir_op[i], res);
            check_val($sformatf("dir%0d", i), res, dir_exp[i]);
        end

        // Result and ready must hold in DONE without a new start.
        held = bus.result;
        repeat (4) @(posedge clk);
        #1;
        check_val("hold_ready", 32'(bus.ready), 32'd1);
        check_val("hold_result", bus.result, 32'h7FC00000);

        // A start pulse while busy is dropped.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.a       = 32'h3F800000;
        bus.b       = 32'h40000000;
        bus.add_sub = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.a       = 32'h3F800000;
        bus.b       = 32'h3F800000;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (!bus.ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("busy_latency", 32'(n), 32'd5);
        check_val("busy_result", bus.result, 32'h40400000);
        repeat (3) @(posedge clk);
        #1;
        check_val("busy_hold", bus.result, 32'h40400000);

        // Reset while the operation sits in ALIGN.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.a       = 32'h404CCCCD;
        bus.b       = 32'h40933333;
        bus.add_sub = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check_val("align_ready", 32'(bus.ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("abort_ready", 32'(bus.ready), 32'd0);
        check_val("abort_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_val("abort_idle_ready", 32'(bus.ready), 32'd0);
        check_val("abort_idle_result", bus.result, 32'd0);

        run_op(32'hC1200000, 32'hC0800000, 1'b1, res);
        check_val("after_abort", res, 32'hC0C00000);

        for (int i = 0; i < 300; i++) begin
            gen_operands(ra, rb, rop);
            run_op(ra, rb, rop, res);
            if (res !== ref_addsub(ra, rb, rop)) begin
                $display("  operands a=%08h b=%08h sub=%0d", ra, rb, rop);
            end
            check_val($sformatf("rand%0d", i), res, ref_addsub(ra, rb, rop));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
